// File: rtl/pkt_mtx_arbiter.sv
// Packet-level least-recently-granted matrix arbiter with an urgent class, starvation aging
// and a lock watchdog. Valid/ready: xfer acts as the handshake; a flit moves when grant is set and xfer=1.
module pkt_mtx_arbiter #(
  parameter int LEN        = 5,
  parameter int STARVE_MAX = 16,
  parameter int HOLD_MAX   = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [LEN-1:0]                request,
  input  logic [LEN-1:0]                urgent,
  input  logic                          xfer,
  input  logic                          tail,
  output logic [LEN-1:0]                grant,
  output logic [($clog2(LEN)|1)-1:0]    grant_id,
  output logic                          locked,
  output logic                          timeout
);

  localparam int IDW = $clog2(LEN) | 1;
  localparam int AW  = $clog2(STARVE_MAX + 1);
  localparam int CW  = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state;
  logic [LEN-1:0] lock_vec;
  logic [LEN-1:0] w [LEN];
  logic [AW-1:0]  age [LEN];
  logic [CW-1:0]  cnt;

  logic [LEN-1:0] eff_urg;
  logic [LEN-1:0] active;
  logic [LEN-1:0] win;
  logic           commit;

  // A starved normal requester competes as if urgent.
  always_comb begin
    eff_urg = '0;
    for (int i = 0; i < LEN; i++)
      eff_urg[i] = request[i] & (urgent[i] | (age[i] == AW'(STARVE_MAX)));
    active = (|eff_urg) ? eff_urg : request;
    win = '0;
    for (int i = 0; i < LEN; i++) begin
      win[i] = active[i];
      for (int j = 0; j < LEN; j++)
        if (j != i && active[j] && w[j][i]) win[i] = 1'b0;
    end
  end

  assign grant  = !rstn ? '0 : ((state == LOCKED) ? lock_vec : win);
  assign locked = (state == LOCKED);
  assign commit = (state == IDLE) & xfer & (|win);

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < LEN; i++)
      if (grant[i]) grant_id = grant_id | IDW'(i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lock_vec <= '0;
      cnt      <= '0;
      timeout  <= 1'b0;
      for (int i = 0; i < LEN; i++) begin
        age[i] <= '0;
        for (int j = 0; j < LEN; j++) w[i][j] <= (i < j);
      end
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          for (int i = 0; i < LEN; i++) begin
            if (!request[i])
              age[i] <= '0;
            else if (commit) begin
              if (win[i])                           age[i] <= '0;
              else if (age[i] != AW'(STARVE_MAX))   age[i] <= age[i] + 1'b1;
            end
          end
          if (commit) begin
            // Winner drops to lowest priority against everyone else.
            for (int i = 0; i < LEN; i++)
              for (int j = 0; j < LEN; j++) begin
                if (win[i])                w[i][j] <= 1'b0;
                else if (win[j] && i != j) w[i][j] <= 1'b1;
              end
            if (!tail) begin
              state    <= LOCKED;
              lock_vec <= win;
            end
          end
        end
        LOCKED: begin
          if (xfer) begin
            cnt <= '0;
            if (tail) begin
              state    <= IDLE;
              lock_vec <= '0;
            end
          end else begin
            if (cnt != CW'(HOLD_MAX)) cnt <= cnt + 1'b1;
            if (cnt >= CW'(HOLD_MAX - 1)) timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_mtx_arbiter.sv
// Bench for pkt_mtx_arbiter: directed vector table, multi-cycle sequences and random traffic
// checked against a recency-list model of least-recently-granted arbitration.
module tb_pkt_mtx_arbiter;

  localparam int LEN = 4;
  localparam int SM  = 3;
  localparam int HM  = 8;
  localparam int IDW = 3;
  localparam int W   = LEN + IDW + 2;

  logic            clk;
  logic            rstn;
  logic [LEN-1:0]  request;
  logic [LEN-1:0]  urgent;
  logic            xfer;
  logic            tail;
  logic [LEN-1:0]  grant;
  logic [IDW-1:0]  grant_id;
  logic            locked;
  logic            timeout;

  int tests;
  int failed;
  logic [W-1:0] exp_q[$];

  pkt_mtx_arbiter #(.LEN(LEN), .STARVE_MAX(SM), .HOLD_MAX(HM)) dut (
    .clk(clk), .rstn(rstn), .request(request), .urgent(urgent), .xfer(xfer), .tail(tail),
    .grant(grant), .grant_id(grant_id), .locked(locked), .timeout(timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: priority is a recency list, front = highest
  int order[$];
  int m_age[LEN];
  bit m_locked;
  int m_lock;
  int m_cnt;
  bit m_to;

  function automatic logic [LEN-1:0] model_grant();
    logic [LEN-1:0] eu;
    logic [LEN-1:0] act;
    if (m_locked) return LEN'(1) << m_lock;
    for (int i = 0; i < LEN; i++)
      eu[i] = request[i] && (urgent[i] || m_age[i] == SM);
    act = (eu != 0) ? eu : request;
    foreach (order[k])
      if (act[order[k]]) return LEN'(1) << order[k];
    return '0;
  endfunction

  int  mw;
  logic [LEN-1:0] mg;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      order = {};
      for (int i = 0; i < LEN; i++) begin
        order.push_back(i);
        m_age[i] = 0;
      end
      m_locked = 0; m_lock = 0; m_cnt = 0; m_to = 0;
    end else begin
      mg = model_grant();
      mw = 0;
      for (int i = 0; i < LEN; i++) if (mg[i]) mw = i;
      if (!m_locked) begin
        m_cnt = 0;
        for (int i = 0; i < LEN; i++) begin
          if (!request[i]) m_age[i] = 0;
          else if (mg != 0 && xfer) m_age[i] = (i == mw) ? 0 : ((m_age[i] + 1 > SM) ? SM : m_age[i] + 1);
        end
        if (mg != 0 && xfer) begin
          for (int k = 0; k < order.size(); k++)
            if (order[k] == mw) begin order.delete(k); break; end
          order.push_back(mw);
          if (!tail) begin m_locked = 1; m_lock = mw; end
        end
      end else if (xfer) begin
        m_cnt = 0;
        if (tail) m_locked = 0;
      end else begin
        if (m_cnt < HM) m_cnt++;
        if (m_cnt >= HM) m_to = 1;
      end
    end
  end

  function automatic logic [W-1:0] pack(input logic [LEN-1:0] g, input logic l, input logic t);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < LEN; i++) if (g[i]) id = IDW'(i);
    return {g, id, l, t};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [W-1:0] e);
    logic [W-1:0] act;
    logic [W-1:0] ex;
    exp_q.push_back(e);
    act = {grant, grant_id, locked, timeout};
    ex  = exp_q.pop_front();
    tests++;
    if (act !== ex) begin
      failed++;
      $display("FAIL %s @%0t: got grant=%b id=%0d locked=%b timeout=%b, expected grant=%b id=%0d locked=%b timeout=%b",
               name, $time, act[W-1 -: LEN], act[IDW+1:2], act[1], act[0],
               ex[W-1 -: LEN], ex[IDW+1:2], ex[1], ex[0]);
    end
  endtask

  // drivers
  task automatic drive(input logic [LEN-1:0] r, input logic [LEN-1:0] u, input logic x, input logic t);
    @(negedge clk);
    request = r; urgent = u; xfer = x; tail = t;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1 check("reset", pack('0, 1'b0, 1'b0));
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [LEN-1:0] req;
    logic [LEN-1:0] urg;
    logic           xf;
    logic           tl;
    logic [LEN-1:0] eg;
    logic           el;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tests = 0; failed = 0;
    rstn = 1'b0; request = '0; urgent = '0; xfer = 1'b0; tail = 1'b0;

    // round robin under full load, then urgent aging
    tbl[0] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[1] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b0};
    tbl[2] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b0};
    tbl[3] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[5] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0};
    tbl[6] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0};
    tbl[7] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0};
    tbl[8] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[9] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0};

    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(tbl[k].req, tbl[k].urg, tbl[k].xf, tbl[k].tl);
      check("t1_rr", pack(tbl[k].eg, tbl[k].el, 1'b0));
    end
    apply_reset();
    for (int k = 5; k < 10; k++) begin
      drive(tbl[k].req, tbl[k].urg, tbl[k].xf, tbl[k].tl);
      check("t4_aging", pack(tbl[k].eg, tbl[k].el, 1'b0));
    end

    // T2 lock hold and release
    apply_reset();
    drive(4'b0101, 4'b0000, 1'b1, 1'b0); check("t2_head", pack(4'b0001, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      drive(4'b0101, 4'b0000, 1'b0, 1'b0); check("t2_hold", pack(4'b0001, 1'b1, 1'b0));
    end
    drive(4'b0101, 4'b0000, 1'b1, 1'b1); check("t2_tail", pack(4'b0001, 1'b1, 1'b0));
    drive(4'b0101, 4'b0000, 1'b0, 1'b0); check("t2_next", pack(4'b0100, 1'b0, 1'b0));

    // T3 urgent
    apply_reset();
    drive(4'b1111, 4'b1000, 1'b0, 1'b0); check("t3_urgent", pack(4'b1000, 1'b0, 1'b0));

    // T5 watchdog
    apply_reset();
    drive(4'b0001, 4'b0000, 1'b1, 1'b0); check("t5_head", pack(4'b0001, 1'b0, 1'b0));
    for (int k = 0; k < HM; k++) begin
      drive(4'b0001, 4'b0000, 1'b0, 1'b0); check("t5_wait", pack(4'b0001, 1'b1, 1'b0));
    end
    drive(4'b0001, 4'b0000, 1'b0, 1'b0); check("t5_timeout", pack(4'b0001, 1'b1, 1'b1));
    drive(4'b0001, 4'b0000, 1'b1, 1'b1); check("t5_tail", pack(4'b0001, 1'b1, 1'b1));
    drive(4'b0001, 4'b0000, 1'b0, 1'b0); check("t5_sticky", pack(4'b0001, 1'b0, 1'b1));

    // T6 reset mid-lock
    apply_reset();
    drive(4'b1111, 4'b0000, 1'b1, 1'b0); check("t6_head", pack(4'b0001, 1'b0, 1'b0));
    drive(4'b1111, 4'b0000, 1'b0, 1'b0); check("t6_locked", pack(4'b0001, 1'b1, 1'b0));
    apply_reset();
    #1 check("t6_release", pack(4'b0001, 1'b0, 1'b0));

    // random traffic against the model; middle stretch starves xfer to exercise the watchdog
    apply_reset();
    for (int n = 0; n < 900; n++) begin
      logic [LEN-1:0] r;
      logic [LEN-1:0] u;
      logic x;
      logic t;
      r = LEN'($urandom_range(0, 15));
      u = ($urandom_range(0, 3) == 0) ? LEN'($urandom_range(0, 15)) : '0;
      x = ($urandom_range(0, 9) < ((n >= 400 && n < 600) ? 1 : 7));
      t = ($urandom_range(0, 2) == 0);
      if (n == 700) apply_reset();
      drive(r, u, x, t);
      check("rand", pack(model_grant(), m_locked, m_to));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
